// File: rtl/ssc_serial_tx_if.sv
// Parallel-side request and serial-side status signals of the frame serializer.
interface ssc_serial_tx_if #(
  parameter int WIDTH = 4
);
  logic             start_in;
  logic [WIDTH-1:0] word_in;
  logic             data_out;
  logic             busy;
  logic             frame_done;

  modport master (output start_in, output word_in,
                  input  data_out, input busy, input frame_done);
  modport slave  (input  start_in, input word_in,
                  output data_out, output busy, output frame_done);
endinterface

// File: rtl/ssc_serial_tx.sv
// Frame serializer: preamble then payload word MSB-first on a one-bit line,
// each bit held BIT_CYCLES clocks, followed by a GAP_BITS idle guard.
module ssc_serial_tx #(
  parameter int                 WIDTH      = 4,
  parameter int                 PRE_LEN    = 4,
  parameter logic [PRE_LEN-1:0] PREAMBLE   = 4'b1101,
  parameter int                 BIT_CYCLES = 1,
  parameter int                 GAP_BITS   = 2
) (
  input  logic            clk_main,
  input  logic            rst,
  ssc_serial_tx_if.slave  tx
);
  localparam int FW    = PRE_LEN + WIDTH;
  localparam int MAX_A = (PRE_LEN > WIDTH) ? PRE_LEN : WIDTH;
  localparam int MAX_B = (MAX_A > GAP_BITS) ? MAX_A : GAP_BITS;
  localparam int IW    = (MAX_B > 1) ? $clog2(MAX_B) : 1;
  localparam int CW    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] PRE_LAST = IW'(PRE_LEN - 1);
  localparam logic [IW-1:0] DAT_LAST = IW'(WIDTH - 1);
  localparam logic [IW-1:0] GAP_LAST = IW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [FW-1:0] sh_q, sh_d;
  logic          data_q, data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          start_q;

  logic          start_rise;
  logic          bit_end;
  logic [FW-1:0] sh_shift;

  assign start_rise = tx.start_in & ~start_q;
  assign bit_end    = (cyc_q == CYC_LAST);
  assign sh_shift   = {sh_q[FW-2:0], 1'b0};

  // Preamble and payload share one shift register; its MSB is the next bit to send.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        data_d = 1'b0;
        busy_d = 1'b0;
        if (start_rise) begin
          sh_d    = {PREAMBLE, tx.word_in};
          state_d = PRE;
          idx_d   = '0;
          cyc_d   = '0;
          data_d  = PREAMBLE[PRE_LEN-1];
          busy_d  = 1'b1;
        end
      end
      PRE, DATA: begin
        if (!bit_end) begin
          cyc_d = cyc_q + 1'b1;
        end else begin
          cyc_d  = '0;
          sh_d   = sh_shift;
          idx_d  = idx_q + 1'b1;
          data_d = sh_shift[FW-1];
          if (state_q == PRE && idx_q == PRE_LAST) begin
            state_d = DATA;
            idx_d   = '0;
          end else if (state_q == DATA && idx_q == DAT_LAST) begin
            done_d = 1'b1;
            data_d = 1'b0;
            idx_d  = '0;
            if (GAP_BITS == 0) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              state_d = GAP;
            end
          end
        end
      end
      GAP: begin
        data_d = 1'b0;
        if (!bit_end) begin
          cyc_d = cyc_q + 1'b1;
        end else begin
          cyc_d = '0;
          if (idx_q == GAP_LAST) begin
            state_d = IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        data_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // start_q resets high so a level already asserted at reset release is not a rise.
  always_ff @(posedge clk_main) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      start_q <= tx.start_in;
    end
  end

  assign tx.data_out   = data_q;
  assign tx.busy       = busy_q;
  assign tx.frame_done = done_q;
endmodule

// File: tb/tb_ssc_serial_tx.sv
// Directed bench: default-parameter serializer (a) and a BIT_CYCLES=3 instance (b).
module tb_ssc_serial_tx;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ssc_serial_tx_if #(.WIDTH(4)) if_a ();
  ssc_serial_tx_if #(.WIDTH(4)) if_b ();

  ssc_serial_tx u_a (.clk_main(clk), .rst(rst_a), .tx(if_a.slave));
  ssc_serial_tx #(.BIT_CYCLES(3)) u_b (.clk_main(clk), .rst(rst_b), .tx(if_b.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame on instance a; expected line values come from 'bits'.
  // hold keeps start high, latch_chg alters word_in after acceptance,
  // glitch pulses start mid-frame.
  task automatic send_a(input string tag, input logic [3:0] w, input logic [7:0] bits,
                        input bit hold, input bit latch_chg, input bit glitch);
    if_a.word_in  = w;
    if_a.start_in = 1'b1;
    step();
    if (!hold) if_a.start_in = 1'b0;
    if (latch_chg) if_a.word_in = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_data"}, 32'(if_a.data_out), 32'(bits[7-i]));
      chk({tag, "_busy"}, 32'(if_a.busy), 32'd1);
      chk({tag, "_done_lo"}, 32'(if_a.frame_done), 32'd0);
      if (glitch && i == 3) if_a.start_in = 1'b1;
      if (glitch && i == 4) if_a.start_in = 1'b0;
      step();
    end
    chk({tag, "_done"}, 32'(if_a.frame_done), 32'd1);
    chk({tag, "_done_data"}, 32'(if_a.data_out), 32'd0);
    chk({tag, "_gap_busy0"}, 32'(if_a.busy), 32'd1);
    step();
    chk({tag, "_gap_busy1"}, 32'(if_a.busy), 32'd1);
    chk({tag, "_gap_done"}, 32'(if_a.frame_done), 32'd0);
    chk({tag, "_gap_data"}, 32'(if_a.data_out), 32'd0);
    step();
    chk({tag, "_idle_busy"}, 32'(if_a.busy), 32'd0);
  endtask

  initial begin
    logic [7:0] sbits;
    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.start_in = 1'b1;
    if_a.word_in  = 4'b0000;
    if_b.start_in = 1'b0;
    if_b.word_in  = 4'b0000;
    repeat (3) step();
    chk("rst_data", 32'(if_a.data_out), 32'd0);
    chk("rst_busy", 32'(if_a.busy), 32'd0);
    chk("rst_done", 32'(if_a.frame_done), 32'd0);
    chk("rst_b_busy", 32'(if_b.busy), 32'd0);

    // start high through reset release must not start a frame
    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("start_at_rst_busy", 32'(if_a.busy), 32'd0);
      chk("start_at_rst_data", 32'(if_a.data_out), 32'd0);
    end
    if_a.start_in = 1'b0;
    step();

    send_a("basic", 4'b1000, 8'b1101_1000, 1'b0, 1'b0, 1'b0);

    // held high ~20 cycles: one frame only
    send_a("hold", 4'b0011, 8'b1101_0011, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("hold_no_retrig", 32'(if_a.busy), 32'd0);
    end
    if_a.start_in = 1'b0;
    step();

    // pulse during busy ignored, pulse right after busy falls accepted
    send_a("glitch", 4'b1001, 8'b1101_1001, 1'b0, 1'b0, 1'b1);
    send_a("after_busy", 4'b0110, 8'b1101_0110, 1'b0, 1'b0, 1'b0);

    send_a("latch", 4'b1000, 8'b1101_1000, 1'b0, 1'b1, 1'b0);

    // checker stream: three back-to-back frames
    send_a("chain0", 4'b1000, 8'b1101_1000, 1'b0, 1'b0, 1'b0);
    send_a("chain1", 4'b0111, 8'b1101_0111, 1'b0, 1'b0, 1'b0);
    send_a("chain2", 4'b1101, 8'b1101_1101, 1'b0, 1'b0, 1'b0);

    // reset while payload bit 2 is on the line
    if_a.word_in  = 4'b1010;
    if_a.start_in = 1'b1;
    step();
    if_a.start_in = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("mid_bit2", 32'(if_a.data_out), 32'd0);
    chk("mid_busy_pre", 32'(if_a.busy), 32'd1);
    rst_a = 1'b1;
    step();
    chk("mid_rst_data", 32'(if_a.data_out), 32'd0);
    chk("mid_rst_busy", 32'(if_a.busy), 32'd0);
    chk("mid_rst_done", 32'(if_a.frame_done), 32'd0);
    rst_a = 1'b0;
    step();
    send_a("post_rst", 4'b0110, 8'b1101_0110, 1'b0, 1'b0, 1'b0);

    // stretched bits on instance b
    sbits = 8'b1101_0101;
    if_b.word_in  = 4'b0101;
    if_b.start_in = 1'b1;
    step();
    if_b.start_in = 1'b0;
    for (int i = 0; i < 24; i++) begin
      chk("stretch_data", 32'(if_b.data_out), 32'(sbits[7 - i/3]));
      chk("stretch_busy", 32'(if_b.busy), 32'd1);
      chk("stretch_done_lo", 32'(if_b.frame_done), 32'd0);
      step();
    end
    chk("stretch_done", 32'(if_b.frame_done), 32'd1);
    chk("stretch_done_data", 32'(if_b.data_out), 32'd0);
    chk("stretch_done_busy", 32'(if_b.busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stretch_gap_busy", 32'(if_b.busy), 32'd1);
      chk("stretch_gap_done", 32'(if_b.frame_done), 32'd0);
    end
    step();
    chk("stretch_idle_busy", 32'(if_b.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ssc_serial_tx.md
# ssc_serial_tx

Upstream frame serializer for the serial sequence checker (`SSC_main`). It takes a parallel data word and a start request, then drives the checker's one-bit `data_in` line one bit at a time. Each frame is a fixed preamble followed by the data word, MSB-first, with a programmable number of clocks per bit and a guard gap between frames. It replaces the hand-written bit stimulus used for the checker so that the same frames can come from board switches or from a testbench.

## Interface

Parameters:
- `WIDTH`, 4: payload word width in bits (≥1).
- `PRE_LEN`, 4: preamble length in bits (≥1).
- `PREAMBLE`, 4'b1101: preamble pattern, `PRE_LEN` bits, sent MSB-first.
- `BIT_CYCLES`, 1: `clk_main` cycles each serial bit is held (≥1).
- `GAP_BITS`, 2: idle bit periods (line = 0) after each frame before a new start is accepted (≥0).

Ports:
- `clk_main` input 1: single clock; all logic on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `start_in` input 1: start request, level input; only a rising edge triggers a frame.
- `word_in` input `WIDTH`: payload, sampled on the accepting edge only.
- `data_out` input→checker, output 1: registered serial line, feeds `SSC_main.data_in`.
- `busy` output 1: frame or guard gap in progress.
- `frame_done` output 1: one-cycle pulse when the last payload bit period ends.

## Operation

- Reset (`rst`=1 at an edge):
  - Outputs: `data_out`=0, `busy`=0, `frame_done`=0.
  - State: IDLE; internal counters 0.
  - `start_q` resets to 1. A `start_in` that is already high when reset releases does not trigger a frame.
- Edge detect:
  - `start_q` <= `start_in` every non-reset cycle, in all states.
  - `start_rise` = `start_in & ~start_q`.
- FSM states: IDLE, PRE, DATA, GAP.
- IDLE:
  - `data_out`=0, `busy`=0.
  - On `start_rise`: latch `word_in` into the shift register, go to PRE with bit index 0, load `data_out` = `PREAMBLE[PRE_LEN-1]`, set `busy`=1.
- PRE:
  - Each bit is held for `BIT_CYCLES` cycles, counted by cycle counter `cyc_cnt`.
  - At the end of each period, advance to the next preamble bit.
  - After bit 0 of the preamble, go to DATA and output `word[WIDTH-1]`.
- DATA:
  - Same per-bit timing as PRE; payload goes out MSB-first.
  - When the last bit (`word[0]`) period ends: pulse `frame_done`=1 for that one cycle, set `data_out`=0.
  - Then go to GAP, or to IDLE with `busy`=0 if `GAP_BITS`=0.
- GAP:
  - `data_out`=0 for `GAP_BITS`×`BIT_CYCLES` cycles, then go to IDLE with `busy`=0.
- Start handling:
  - A `start_rise` while `busy`=1 is ignored, not queued.
  - `start_in` held high across the end of a frame does not retrigger, because `start_q` is already 1.
- Latching: `word_in` changes after acceptance do not affect the frame in flight.
- Counters:
  - `cyc_cnt` width is `$clog2(BIT_CYCLES)` (minimum 1).
  - Bit index width is `$clog2(max(PRE_LEN, WIDTH, GAP_BITS))` (minimum 1).
  - No counter wraps mid-state.
- Reset mid-frame: takes effect at the next edge, regardless of state. Outputs return to reset values and the partial frame is abandoned.

## Timing

- Acceptance latency: a rise sampled at edge k puts the first preamble bit on `data_out` right after edge k. It is registered, not combinational.
- Frame length: (`PRE_LEN`+`WIDTH`)×`BIT_CYCLES` cycles of `data_out` activity, starting at edge k.
- `frame_done`:
  - Asserted during the cycle after edge k+(`PRE_LEN`+`WIDTH`)×`BIT_CYCLES`.
  - In that same cycle `data_out`=0.
- `busy`:
  - Asserted after edge k.
  - Deasserted after edge k+(`PRE_LEN`+`WIDTH`+`GAP_BITS`)×`BIT_CYCLES`.
- Earliest next frame: a new `start_rise` is accepted at the first edge where `busy` is seen as 0, i.e. in IDLE.
- Back-to-back: minimum frame spacing is (`PRE_LEN`+`WIDTH`+`GAP_BITS`)×`BIT_CYCLES`+1 cycles, because `start_in` must go low and rise again.

## Test plan

- Basic frame (defaults, `word_in`=4'b1000, one start pulse):
  - `data_out` = 1,1,0,1,1,0,0,0 over 8 consecutive cycles.
  - `frame_done` high only in the 9th cycle.
  - `busy` high for exactly 10 cycles.
- Checker chain: three frames with words 4'b1000, 4'b0111, 4'b1101, driven into `SSC_main`. The full bit stream must match, bit for bit, the sequence the checker's directed test expects, and `success_light` must assert.
- Bit stretching (`BIT_CYCLES`=3, `word_in`=4'b0101):
  - Each bit is held 3 cycles, giving 24 active cycles.
  - `frame_done` occurs at cycle 25; `busy` spans 30 cycles.
- Start rules:
  - `start_in` high through reset release → no frame.
  - `start_in` held high for 20 cycles → exactly one frame.
  - A second pulse while `busy` → ignored.
  - A pulse one cycle after `busy` falls → accepted.
- Data latch: change `word_in` from 4'b1000 to 4'b1111 one cycle after acceptance. The payload sent is still 1,0,0,0.
- Mid-frame reset: assert `rst` during payload bit 2.
  - Next cycle: `data_out`=0, `busy`=0, `frame_done`=0.
  - A new start afterwards produces a complete, correct frame.
